mem_load_arbiter: RTL and testbench

Shares the single 16x8 program RAM between the CPU datapath and an external program loader (DIP-switch panel or UART front end). In RUN mode the CPU owns the RAM port; on a program request the block stalls the CPU, hands the RAM to the loader through a valid/ready handshake, and then restarts the CPU from address 0 with a one-cycle reset pulse. It sits between the CPU's memory address register/RAM control lines and the RAM instance at the top level.

---
 rtl/mem_load_arbiter_pkg.sv | 18 +
 rtl/mem_load_arbiter_if.sv | 30 +++
 rtl/mem_load_arbiter_ram_port_mux.sv | 41 ++++
 rtl/mem_load_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_load_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_load_arbiter_pkg.sv
// mem_load_arbiter shared types and defaults.
// Optional read-back verify: LOADER_VERIFY_EN.
package mem_load_arbiter_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int RAM_DEPTH  = 2 ** ADDR_W_DEF;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_HALT    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_VERIFY  = 3'd4,
    ST_RELEASE = 3'd5
  } state_e;

endpackage

// File: rtl/mem_load_arbiter_if.sv
// Program loader handshake bundle.
// Master = loader front end, slave = arbiter.
interface mem_load_arbiter_if #(
  parameter int ADDR_W = mem_load_arbiter_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_load_arbiter_pkg::DATA_W_DEF
);

  logic              prog_req;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  modport master (
    output prog_req,
    output ld_valid,
    output ld_addr,
    output ld_data,
    input  ld_ready
  );

  modport slave (
    input  prog_req,
    input  ld_valid,
    input  ld_addr,
    input  ld_data,
    output ld_ready
  );

endinterface

// File: rtl/mem_load_arbiter_ram_port_mux.sv
// 2:1 RAM port select between CPU and loader.
// CPU read data is zeroed when the CPU is not the owner.
module ram_port_mux #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              sel_cpu,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_we,
  input  logic              ld_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  // route the owner's request onto the RAM port
  always_comb begin
    if (sel_cpu) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
      ram_re    = cpu_re;
      cpu_rdata = ram_rdata;
    end else begin
      ram_addr  = ld_addr;
      ram_wdata = ld_wdata;
      ram_we    = ld_we;
      ram_re    = ld_re;
      cpu_rdata = '0;
    end
  end

endmodule

// File: rtl/mem_load_arbiter.sv
// Program RAM arbiter: CPU run mode vs loader.
// Optional read-back verify: LOADER_VERIFY_EN.
module mem_load_arbiter
  import mem_load_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_load_arbiter_if.slave ld,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_rst,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              prog_mode,
  output logic [ADDR_W:0]   wr_count,
  output logic              verr
);

  localparam logic [ADDR_W:0] WR_MAX =
    (ADDR_W+1)'(2 ** ADDR_W);

  state_e            state;
  state_e            state_nx;
  state_e            st_o;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W:0]   wr_cnt_q;
  logic              sel_cpu;
  logic              rdy;
  logic              l_we;
  logic              l_re;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RUN:
        if (ld.prog_req) state_nx = ST_HALT;
      ST_HALT:
        state_nx = ST_LOAD;
      ST_LOAD:
        if (ld.ld_valid)
          state_nx = ST_WRITE;
        else if (!ld.prog_req)
          state_nx = ST_RELEASE;
      ST_WRITE:
`ifdef LOADER_VERIFY_EN
        state_nx = ST_VERIFY;
`else
        state_nx = ST_LOAD;
`endif
      ST_VERIFY:
        state_nx = ST_LOAD;
      ST_RELEASE:
        state_nx = ST_RUN;
      default:
        state_nx = ST_RUN;
    endcase
  end

  // outputs; reset cycle looks like RUN
  always_comb begin
    st_o      = rst ? ST_RUN : state;
    sel_cpu   = 1'b0;
    cpu_stall = 1'b1;
    rdy       = 1'b0;
    prog_mode = 1'b0;
    cpu_rst   = 1'b0;
    l_we      = 1'b0;
    l_re      = 1'b0;
    unique case (st_o)
      ST_RUN: begin
        sel_cpu   = 1'b1;
        cpu_stall = 1'b0;
      end
      ST_LOAD: begin
        rdy       = 1'b1;
        prog_mode = 1'b1;
      end
      ST_WRITE: begin
        prog_mode = 1'b1;
        l_we      = 1'b1;
      end
      ST_VERIFY: begin
        prog_mode = 1'b1;
        l_re      = 1'b1;
      end
      ST_RELEASE:
        cpu_rst = 1'b1;
      default: ;
    endcase
  end

  assign ld.ld_ready = rdy;
  assign wr_count    = wr_cnt_q;

  // capture accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_addr <= '0;
      hold_data <= '0;
    end else if (rdy && ld.ld_valid) begin
      hold_addr <= ld.ld_addr;
      hold_data <= ld.ld_data;
    end
  end

  // beats written this session, saturating
  always_ff @(posedge clk) begin
    if (rst)
      wr_cnt_q <= '0;
    else if (state == ST_HALT)
      wr_cnt_q <= '0;
    else if (state == ST_WRITE &&
             wr_cnt_q != WR_MAX)
      wr_cnt_q <= wr_cnt_q + 1'b1;
  end

`ifdef LOADER_VERIFY_EN
  logic verr_q;

  // sticky read-back mismatch flag
  always_ff @(posedge clk) begin
    if (rst)
      verr_q <= 1'b0;
    else if (state == ST_HALT)
      verr_q <= 1'b0;
    else if (state == ST_VERIFY &&
             ram_rdata != hold_data)
      verr_q <= 1'b1;
  end

  assign verr = verr_q;
`else
  assign verr = 1'b0;
`endif

  ram_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .sel_cpu   (sel_cpu),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we & ~rst),
    .cpu_re    (cpu_re),
    .cpu_rdata (cpu_rdata),
    .ld_addr   (hold_addr),
    .ld_wdata  (hold_data),
    .ld_we     (l_we),
    .ld_re     (l_re),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_load_arbiter.sv
// Directed bench for mem_load_arbiter.
// Verify-path checks follow LOADER_VERIFY_EN.
module tb_mem_load_arbiter;

`ifdef LOADER_VERIFY_EN
  localparam logic VER = 1'b1;
`else
  localparam logic VER = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] cpu_addr;
  logic       cpu_we;
  logic       cpu_re;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       cpu_rst;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       ram_re;
  logic [7:0] ram_rdata;
  logic       prog_mode;
  logic [4:0] wr_count;
  logic       verr;

  logic       mem_init;
  logic       stuck_en;
  logic [7:0] mem [16];

  int chk_cnt;
  int pass_cnt;

  mem_load_arbiter_if #(
    .ADDR_W (4),
    .DATA_W (8)
  ) lif ();

  mem_load_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .ld        (lif),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .cpu_rst   (cpu_rst),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .prog_mode (prog_mode),
    .wr_count  (wr_count),
    .verr      (verr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model write port
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= 8'h00;
      mem[3] <= 8'h1E;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  // RAM model read port, optional stuck bit
  always_comb begin
    ram_rdata = 8'h00;
    if (ram_re) begin
      ram_rdata = mem[ram_addr];
      if (stuck_en && ram_addr == 4'd5)
        ram_rdata[0] = 1'b0;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    chk_cnt++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    else
      pass_cnt++;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (!lif.ld_ready && n < 8) begin
      step();
      n++;
    end
    chk("rdy_wait", lif.ld_ready, 1);
  endtask

  task automatic send_beat(
    input logic [3:0] a,
    input logic [7:0] d
  );
    wait_rdy();
    lif.ld_valid = 1'b1;
    lif.ld_addr  = a;
    lif.ld_data  = d;
    step();
    chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, a);
    chk("wr_data", ram_wdata, d);
    lif.ld_valid = 1'b0;
    step();
  endtask

  initial begin
    chk_cnt      = 0;
    pass_cnt     = 0;
    rst          = 1'b1;
    mem_init     = 1'b1;
    stuck_en     = 1'b0;
    cpu_addr     = '0;
    cpu_we       = 1'b0;
    cpu_re       = 1'b0;
    cpu_wdata    = '0;
    lif.prog_req = 1'b0;
    lif.ld_valid = 1'b0;
    lif.ld_addr  = '0;
    lif.ld_data  = '0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    mem_init = 1'b0;
    #1;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rdy", lif.ld_ready, 0);
    chk("rst_pmode", prog_mode, 0);
    chk("rst_crst", cpu_rst, 0);
    chk("rst_cnt", wr_count, 0);
    chk("rst_verr", verr, 0);

    // CPU read plus program request
    @(negedge clk);
    cpu_addr     = 4'd3;
    cpu_re       = 1'b1;
    lif.prog_req = 1'b1;
    #1;
    chk("run_rdata", cpu_rdata, 8'h1E);
    chk("run_stall", cpu_stall, 0);
    chk("run_re", ram_re, 1);
    step();
    chk("halt_stall", cpu_stall, 1);
    chk("halt_rdata", cpu_rdata, 0);
    chk("halt_re", ram_re, 0);
    chk("halt_rdy", lif.ld_ready, 0);
    cpu_re = 1'b0;
    step();
    chk("load_rdy", lif.ld_ready, 1);
    chk("load_pmode", prog_mode, 1);

    // full fill then overwrite addr 0
    for (int i = 0; i < 16; i++)
      send_beat(4'(i), 8'(8'h10 + i));
    wait_rdy();
    chk("cnt_16", wr_count, 16);
    send_beat(4'd0, 8'hA5);
    wait_rdy();
    chk("cnt_sat", wr_count, 16);
    chk("mem_0", mem[0], 8'hA5);
    for (int i = 1; i < 16; i++)
      chk("mem_i", mem[i], 8'h10 + i);

    // release back to run
    lif.prog_req = 1'b0;
    step();
    chk("rel_crst", cpu_rst, 1);
    chk("rel_stall", cpu_stall, 1);
    chk("rel_pmode", prog_mode, 0);
    step();
    chk("run_crst", cpu_rst, 0);
    chk("run_stall2", cpu_stall, 0);
    cpu_addr = 4'd0;
    cpu_re   = 1'b1;
    #1;
    chk("fetch0", cpu_rdata, 8'hA5);
    cpu_re = 1'b0;

    // verify path with stuck bit at addr 5
    stuck_en     = 1'b1;
    lif.prog_req = 1'b1;
    step();
    step();
    chk("v_verr0", verr, 0);
    send_beat(4'd5, 8'h01);
    wait_rdy();
    chk("v_set", verr, VER);
    chk("v_mem5", mem[5], 8'h01);
    send_beat(4'd2, 8'h22);
    wait_rdy();
    chk("v_hold", verr, VER);
    chk("v_cnt2", wr_count, 2);
    lif.prog_req = 1'b0;
    step();
    step();
    chk("v_run", verr, VER);
    lif.prog_req = 1'b1;
    step();
    step();
    chk("v_clr", verr, 0);
    chk("v_rdy", lif.ld_ready, 1);

    // reset while a beat is in WRITE
    lif.ld_valid = 1'b1;
    lif.ld_addr  = 4'd7;
    lif.ld_data  = 8'hEE;
    step();
    chk("r_inwr", ram_we, 1);
    rst          = 1'b1;
    lif.ld_valid = 1'b0;
    lif.prog_req = 1'b0;
    #1;
    chk("r_we", ram_we, 0);
    chk("r_stall", cpu_stall, 0);
    chk("r_pmode", prog_mode, 0);
    step();
    rst = 1'b0;
    #1;
    chk("r_mem7", mem[7], 8'h17);
    chk("r_cnt", wr_count, 0);
    chk("r_rdy", lif.ld_ready, 0);
    chk("r_stall2", cpu_stall, 0);
    chk("r_verr", verr, 0);

    // CPU write passes through in RUN
    cpu_addr  = 4'd9;
    cpu_wdata = 8'h99;
    cpu_we    = 1'b1;
    step();
    cpu_we = 1'b0;
    chk("cpu_wr", mem[9], 8'h99);

    $display("%0d/%0d checks passed",
             pass_cnt, chk_cnt);
    $finish;
  end

endmodule
